// File: rtl/pkt_tx.sv
// Packet transmitter: serialises 8-byte data frames or all-0xFF kill frames over a valid/ready byte stream.
// Define PKT_TX_CHKSUM_EN to fill data-frame byte B6 with the XOR checksum of B1..B5; otherwise B6 is 0x00.
module pkt_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  veh_id,
    input  logic [7:0]  dest_id,
    input  logic [15:0] data,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic        kill_req,
    output logic [7:0]  tx_frame,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [7:0] SOF_BYTE  = 8'h96;
    localparam logic [7:0] TYPE_BYTE = 8'h0F;
    localparam logic [7:0] EOF_BYTE  = 8'h62;
    localparam logic [7:0] KILL_BYTE = 8'hFF;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  idx;
    logic [2:0]  idx_nx;
    logic        kill_pending;
    logic        kill_pending_nx;
    logic        kind_kill;
    logic        kind_kill_nx;
    logic        capture;

    logic [7:0]  dest_r;
    logic [7:0]  veh_r;
    logic [15:0] data_r;
    logic [7:0]  chksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            kill_pending <= 1'b0;
            kind_kill    <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            kill_pending <= kill_pending_nx;
            kind_kill    <= kind_kill_nx;
        end
    end

    // Frame fields are snapshotted at accept so input changes during SEND cannot leak into the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_r <= '0;
            veh_r  <= '0;
            data_r <= '0;
        end else if (capture) begin
            dest_r <= dest_id;
            veh_r  <= veh_id;
            data_r <= data;
        end
    end

    always_comb begin
        data_ready = (state == IDLE) && !kill_req && !kill_pending;
    end

    always_comb begin
        state_nx        = state;
        idx_nx          = idx;
        kill_pending_nx = kill_pending;
        kind_kill_nx    = kind_kill;
        capture         = 1'b0;
        case (state)
            IDLE: begin
                if (kill_req || kill_pending) begin
                    state_nx        = SEND;
                    idx_nx          = '0;
                    kind_kill_nx    = 1'b1;
                    kill_pending_nx = 1'b0;
                end else if (data_valid && data_ready) begin
                    state_nx     = SEND;
                    idx_nx       = '0;
                    kind_kill_nx = 1'b0;
                    capture      = 1'b1;
                end
            end
            SEND: begin
                if (kill_req) begin
                    kill_pending_nx = 1'b1;
                end
                if (tx_ready) begin
                    if (idx == 3'd7) begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef PKT_TX_CHKSUM_EN
    always_comb begin
        chksum = TYPE_BYTE ^ dest_r ^ veh_r ^ data_r[15:8] ^ data_r[7:0];
    end
`else
    always_comb begin
        chksum = '0;
    end
`endif

    always_comb begin
        tx_valid = (state == SEND);
        busy     = (state == SEND);
        tx_frame = '0;
        if (state == SEND) begin
            if (kind_kill) begin
                tx_frame = KILL_BYTE;
            end else begin
                case (idx)
                    3'd0:    tx_frame = SOF_BYTE;
                    3'd1:    tx_frame = TYPE_BYTE;
                    3'd2:    tx_frame = dest_r;
                    3'd3:    tx_frame = veh_r;
                    3'd4:    tx_frame = data_r[15:8];
                    3'd5:    tx_frame = data_r[7:0];
                    3'd6:    tx_frame = chksum;
                    default: tx_frame = EOF_BYTE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pkt_tx.sv
// Directed self-checking bench for pkt_tx: frame content, back-pressure, kill handling and mid-frame reset.
// Expected B6 follows PKT_TX_CHKSUM_EN as seen by this compile.
module tb_pkt_tx;

    logic        clk;
    logic        rst;
    logic [7:0]  veh_id;
    logic [7:0]  dest_id;
    logic [15:0] data;
    logic        data_valid;
    logic        data_ready;
    logic        kill_req;
    logic [7:0]  tx_frame;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    int vectors;
    int miscompares;

`ifdef PKT_TX_CHKSUM_EN
    localparam logic [7:0] CK_A = 8'h2A;
    localparam logic [7:0] CK_B = 8'hC7;
`else
    localparam logic [7:0] CK_A = 8'h00;
    localparam logic [7:0] CK_B = 8'h00;
`endif

    localparam logic [63:0] EXP_A    = {8'h96, 8'h0F, 8'h02, 8'h01, 8'h12, 8'h34, CK_A, 8'h62};
    localparam logic [63:0] EXP_B    = {8'h96, 8'h0F, 8'hA5, 8'h3C, 8'hBE, 8'hEF, CK_B, 8'h62};
    localparam logic [63:0] EXP_KILL = {8{8'hFF}};

    pkt_tx dut (
        .clk        (clk),
        .rst        (rst),
        .veh_id     (veh_id),
        .dest_id    (dest_id),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .kill_req   (kill_req),
        .tx_frame   (tx_frame),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Accept edge happens here; on return B0 should be on the bus.
    task automatic start_payload(input logic [7:0] d, input logic [7:0] v, input logic [15:0] w);
        dest_id    = d;
        veh_id     = v;
        data       = w;
        data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
    endtask

    task automatic recv_frame(input string name, input logic [63:0] exp, input bit stall,
                              input logic [7:0] kill_mask);
        int k;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            tx_ready = stall ? (c % 3 == 0) : 1'b1;
            kill_req = kill_mask[k];
            #1;
            vectors++;
            if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_frame !== exp[63-8*k -: 8]) begin
                miscompares++;
                $display("FAIL %s byte%0d: got valid=%b busy=%b frame=%h, want valid=1 busy=1 frame=%h",
                         name, k, tx_valid, busy, tx_frame, exp[63-8*k -: 8]);
                if (tx_valid !== 1'b1) break;
            end
            if (tx_ready) k++;
            cyc();
        end
        kill_req = 1'b0;
        tx_ready = 1'b1;
        vectors++;
        if (k !== 8) begin
            miscompares++;
            $display("FAIL %s transfers: got %0d, want 8", name, k);
        end
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end_idle: got valid=%b busy=%b, want 0 0", name, tx_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if (tx_valid !== 1'b0 || tx_frame !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b frame=%h busy=%b, want 0 00 0",
                     tx_valid, tx_frame, busy);
        end
        cyc();
        rst = 1'b0;
        #1;
        vectors++;
        if (data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, want 1", data_ready);
        end
        kill_req = 1'b1;
        #1;
        vectors++;
        if (data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_kill_req: got %b, want 0", data_ready);
        end
        kill_req = 1'b0;
        cyc();
    endtask

    task automatic test_data_frame();
        dest_id = 8'h02;
        veh_id  = 8'h01;
        data    = 16'h1234;
        data_valid = 1'b1;
        #1;
        vectors++;
        if (data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL data_ready_idle: got %b, want 1", data_ready);
        end
        cyc();
        data_valid = 1'b0;
        recv_frame("data_frame", EXP_A, 1'b0, 8'h00);
        vectors++;
        if (data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL data_ready_after: got %b, want 1", data_ready);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        start_payload(8'hA5, 8'h3C, 16'hBEEF);
        dest_id = 8'h00;
        veh_id  = 8'hEE;
        data    = 16'h5555;
        vectors++;
        if (data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_in_send: got %b, want 0", data_ready);
        end
        recv_frame("backpressure", EXP_B, 1'b1, 8'h00);
        cyc();
    endtask

    task automatic test_kill_priority();
        dest_id    = 8'h02;
        veh_id     = 8'h01;
        data       = 16'h1234;
        data_valid = 1'b1;
        kill_req   = 1'b1;
        #1;
        vectors++;
        if (data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL kill_prio_ready: got %b, want 0", data_ready);
        end
        cyc();
        kill_req = 1'b0;
        recv_frame("kill_prio", EXP_KILL, 1'b0, 8'h00);
        vectors++;
        if (data_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL held_payload_ready: got %b, want 1", data_ready);
        end
        cyc();
        data_valid = 1'b0;
        recv_frame("held_payload", EXP_A, 1'b0, 8'h00);
        cyc();
    endtask

    task automatic test_kill_during_send();
        start_payload(8'h02, 8'h01, 16'h1234);
        recv_frame("kill_mid_data", EXP_A, 1'b0, 8'b0010_1000);
        vectors++;
        if (data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_ready: got %b, want 0", data_ready);
        end
        cyc();
        recv_frame("kill_follow", EXP_KILL, 1'b0, 8'h00);
        cyc();
        vectors++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_kill: got valid=%b busy=%b, want 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_reset_midframe();
        start_payload(8'h02, 8'h01, 16'h1234);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        vectors++;
        if (tx_frame !== 8'h12 || tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_b4: got valid=%b frame=%h, want 1 12", tx_valid, tx_frame);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || tx_frame !== 8'h00 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%b frame=%h busy=%b, want 0 00 0",
                     tx_valid, tx_frame, busy);
        end
        cyc();
        rst = 1'b0;
        #1;
        vectors++;
        if (data_ready !== 1'b1 || tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: got ready=%b valid=%b, want 1 0", data_ready, tx_valid);
        end
        start_payload(8'h02, 8'h01, 16'h1234);
        recv_frame("after_reset", EXP_A, 1'b0, 8'h00);
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        veh_id      = '0;
        dest_id     = '0;
        data        = '0;
        data_valid  = 1'b0;
        kill_req    = 1'b0;
        tx_ready    = 1'b1;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_data_frame();
        test_backpressure();
        test_kill_priority();
        test_kill_during_send();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pkt_tx.md
PKT_TX -- requirements
Module: pkt_tx

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 veh_id  input  8  own vehicle ID, written into the frame source field.
REQ-004 dest_id  input  8  destination ID, captured with data.
REQ-005 data  input  16  payload word.
REQ-006 data_valid  input  1  payload request.
REQ-007 data_ready  output  1  block can accept a payload this cycle.
REQ-008 kill_req  input  1  request to send a kill frame.
REQ-009 tx_frame  output  8  outgoing frame byte.
REQ-010 tx_valid  output  1  tx_frame holds a valid byte.
REQ-011 tx_ready  input  1  sink accepts the byte.
REQ-012 busy  output  1  a frame is in flight (state SEND).

Function
REQ-013 Frame format: 8 bytes, MSB-first order B0..B7. B0 is 0x96 (SOF). B1 is 0x0F (type). B2 is dest_id. B3 is veh_id. B4 is data[15:8]. B5 is data[7:0]. B6 is the checksum (REQ-030). B7 is 0x62 (EOF).
REQ-014 Kill frame: 8 bytes, all 0xFF.
REQ-015 States: IDLE and SEND; 3-bit byte index; 1-bit kill_pending flag; 1-bit kind flag (data or kill).
REQ-016 Payload accept: data_valid && data_ready at a rising edge.
  - Captures dest_id, veh_id and data into frame registers.
  - Moves to SEND with index 0.
REQ-017 data_ready = 1 only in IDLE with kill_req = 0 and kill_pending = 0.
REQ-018 Kill start: in IDLE, kill_req or kill_pending at a rising edge moves to SEND with kind = kill and clears kill_pending.
REQ-019 Kill priority: kill_req and data_valid high in the same IDLE cycle -> kill frame sent, payload not accepted.
REQ-020 Latency: tx_valid = 1 with B0 in the cycle after the accept/kill edge.
REQ-021 Byte transfer occurs on tx_valid && tx_ready; index increments on each transfer.
REQ-022 While tx_valid && !tx_ready, tx_frame and tx_valid are held stable.
REQ-023 tx_valid = 1 for every cycle in SEND, including back-pressure cycles.
REQ-024 Transfer of B7 returns to IDLE; tx_valid = 0 in the next cycle.
  - Minimum one idle cycle between frames.
REQ-025 kill_req asserted during SEND sets kill_pending.
  - The current frame completes unaltered.
  - The kill frame follows from IDLE.
REQ-026 Multiple kill_req pulses during one frame yield one kill frame.
REQ-027 Input changes on data, dest_id and veh_id during SEND do not affect the frame in flight.
REQ-028 busy = 1 exactly when in SEND.

Reset
REQ-029 On rst, asynchronously and regardless of frame progress:
  - state returns to IDLE; index, kill_pending and kind are cleared.
  - tx_valid = 0, tx_frame = 0x00, busy = 0.
  - data_ready = 1 once rst deasserts, provided kill_req = 0.
  - A partially sent frame is abandoned and is not resumed.

Configuration
REQ-030 Macro PKT_TX_CHKSUM_EN controls B6 of data frames; kill frames are unaffected.
  - Defined: B6 = B1 ^ B2 ^ B3 ^ B4 ^ B5.
  - Undefined: B6 = 0x00.

Verification
REQ-031 veh_id=0x01, dest_id=0x02, data=0x1234, tx_ready=1, macro defined -> bytes 96 0F 02 01 12 34 2A 62 on consecutive cycles, then tx_valid=0.
REQ-032 Same stimulus, macro undefined -> 96 0F 02 01 12 34 00 62.
REQ-033 kill_req and data_valid both high in IDLE -> data_ready=0 and eight 0xFF bytes sent; the payload is sent only if data_valid is still held afterwards.
REQ-034 tx_ready toggled 1,0,0,1,... during a frame -> tx_frame held through stalls; exactly 8 transfers; byte order intact.
REQ-035 kill_req pulsed at B3 of a data frame -> data frame completes; one idle cycle; FF x8 follows.
REQ-036 rst asserted at B4 -> tx_valid=0 immediately; after release the next accepted payload starts at 0x96.
